// File: rtl/jtag_types_pkg.sv
// Shared JTAG types: instruction width, opcodes and the decoded DR-select bundle.
package jtag_types_pkg;

    localparam int IR_WIDTH = 5;

    typedef logic [IR_WIDTH-1:0] instr_t;

    localparam instr_t OP_EXTEST         = 5'b00000;
    localparam instr_t OP_IDCODE         = 5'b00001;
    localparam instr_t OP_SAMPLE_PRELOAD = 5'b00010;
    localparam instr_t OP_BYPASS         = 5'b11111;

    localparam instr_t IR_CAPTURE_PAT    = 5'b00001;

    typedef struct packed {
        logic bsr_sel;
        logic extest;
        logic idcode_sel;
        logic bypass_sel;
    } dr_sel_t;

endpackage

// File: rtl/jtag_instr_decode.sv
// Combinational decode of the active instruction into data-register selects.
module jtag_instr_decode
    import jtag_types_pkg::*;
(
    input  instr_t  instr,
    output dr_sel_t sel
);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = '{bsr_sel: 1'b0, extest: 1'b0, idcode_sel: 1'b0, bypass_sel: 1'b1};
        case (instr)
            OP_EXTEST:         sel = '{bsr_sel: 1'b1, extest: 1'b1, idcode_sel: 1'b0, bypass_sel: 1'b0};
            OP_SAMPLE_PRELOAD: sel = '{bsr_sel: 1'b1, extest: 1'b0, idcode_sel: 1'b0, bypass_sel: 1'b0};
            OP_IDCODE:         sel = '{bsr_sel: 1'b0, extest: 1'b0, idcode_sel: 1'b1, bypass_sel: 1'b0};
            default:           ;
        endcase
    end

endmodule

// File: rtl/jtag_ir_dr.sv
// JTAG IR shift/update stages, BYPASS and IDCODE data registers, and the TDO mux.
module jtag_ir_dr
    import jtag_types_pkg::*;
#(
    parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001
) (
    input  logic   TCK,
    input  logic   TRST,
    input  logic   tdi,
    input  logic   test_reset,
    input  logic   ir_capture,
    input  logic   ir_shift,
    input  logic   ir_update,
    input  logic   dr_capture,
    input  logic   dr_shift,
    input  logic   bsr_tdo,
    output instr_t instr,
    output logic   bsr_sel,
    output logic   extest,
    output logic   tdo,
    output logic   tdo_en
);

    instr_t      ir_sr;
    logic        bypass_r;
    logic [31:0] id_sr;
    dr_sel_t     sel;

    jtag_instr_decode u_decode (
        .instr (instr),
        .sel   (sel)
    );

    // Strobes are one-hot from the TAP; the else-if chain only settles illegal overlap.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            instr    <= OP_IDCODE;
            ir_sr    <= '0;
            bypass_r <= 1'b0;
            id_sr    <= '0;
        end else if (test_reset) begin
            // NOTE: non-blocking everywhere here so ir_update sees the pre-edge ir_sr.
            instr <= OP_IDCODE;
            ir_sr <= IR_CAPTURE_PAT;
        end else if (ir_capture || dr_capture) begin
            if (ir_capture) ir_sr <= IR_CAPTURE_PAT;
            if (dr_capture) begin
                if (sel.bypass_sel) bypass_r <= 1'b0;
                if (sel.idcode_sel) id_sr    <= IDCODE_VALUE;
            end
        end else if (ir_shift || dr_shift) begin
            if (ir_shift) ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]};
            if (dr_shift) begin
                if (sel.bypass_sel) bypass_r <= tdi;
                if (sel.idcode_sel) id_sr    <= {tdi, id_sr[31:1]};
            end
        end else if (ir_update) begin
            instr <= ir_sr;
        end
    end

    assign bsr_sel = sel.bsr_sel;
    assign extest  = sel.extest;
    assign tdo_en  = ir_shift | dr_shift;

    always_comb begin
        tdo = 1'b0;
        if (ir_shift) begin
            tdo = ir_sr[0];
        end else if (dr_shift) begin
            if (sel.bsr_sel)         tdo = bsr_tdo;
            else if (sel.idcode_sel) tdo = id_sr[0];
            else                     tdo = bypass_r;
        end
    end

endmodule

// File: doc/jtag_ir_dr.md
Name: jtag_ir_dr

Overview:
Instruction-register and data-register datapath driven by the TAP controller's decoded state strobes. It holds the IR shift/update stages and decodes the active instruction. It also owns the BYPASS and IDCODE data registers and muxes the serial TDO path, including the boundary-scan chain's serial output. It sits directly downstream of the TAP controller and upstream of the TDO pad retiming in the top level.

Parameters:
IDCODE_VALUE, 32'h1000_0001, device ID captured into the IDCODE DR; bit 0 must be 1.

Ports:
TCK  input  1  test clock; all state updates on posedge
TRST  input  1  asynchronous active-low reset
tdi  input  1  serial test data in
test_reset  input  1  TAP in TEST_LOGIC_RESET
ir_capture  input  1  TAP in CAPTURE_IR
ir_shift  input  1  TAP in SHIFT_IR
ir_update  input  1  TAP in UPDATE_IR
dr_capture  input  1  TAP in CAPTURE_DR
dr_shift  input  1  TAP in SHIFT_DR
bsr_tdo  input  1  serial out of the external boundary-scan chain
instr  output  IR_WIDTH  active (updated) instruction
bsr_sel  output  1  boundary-scan chain selected (EXTEST or SAMPLE_PRELOAD)
extest  output  1  EXTEST active; pins driven from BSR update stage
tdo  output  1  serial data out (combinational from regs)
tdo_en  output  1  tdo valid / pad output enable

Behaviour:
- Clock and reset: one clock, TCK. Reset is TRST, asynchronous and active-low.
- Async reset values (TRST=0):
  - instr = OP_IDCODE; ir_sr = 0; bypass_r = 0; id_sr = 0.
  - Derived outputs at reset: bsr_sel=0, extest=0, tdo=0, tdo_en=0.
- Strobe priority per posedge: test_reset > capture > shift > update. The TAP controller guarantees the strobes are one-hot; the priority only resolves illegal overlap.
- test_reset=1: instr <= OP_IDCODE; ir_sr <= capture pattern. DR registers hold.
- IR stages:
  - ir_capture: ir_sr <= {'0, 2'b01}. The LSBs 01 are mandatory.
  - ir_shift: ir_sr <= {tdi, ir_sr[IR_WIDTH-1:1]}, LSB shifted out first.
  - ir_update: instr <= ir_sr. This is the only path that changes instr besides reset and test_reset.
  - instr holds through all DR activity.
- Decode of instr (combinational):
  - OP_EXTEST: bsr selected, extest=1.
  - OP_SAMPLE_PRELOAD: bsr selected, extest=0.
  - OP_IDCODE: IDCODE DR selected.
  - OP_BYPASS and every undefined opcode: BYPASS DR selected.
- BYPASS DR (1 bit, BYPASS selected only):
  - dr_capture: bypass_r <= 0.
  - dr_shift: bypass_r <= tdi.
- IDCODE DR (32 bit, IDCODE selected only):
  - dr_capture: id_sr <= IDCODE_VALUE.
  - dr_shift: id_sr <= {tdi, id_sr[31:1]}.
- Unselected DRs hold their value.
- TDO mux (combinational):
  - ir_shift: tdo = ir_sr[0].
  - dr_shift: tdo = bypass_r, id_sr[0] or bsr_tdo, per the selected DR.
  - Otherwise tdo=0.
  - tdo_en = ir_shift | dr_shift.
- Latency:
  - tdo reflects the register LSB during the shift cycle. Shifted-in tdi appears at tdo after a DR-length of posedges: 1 for BYPASS, 32 for IDCODE.
  - Falling-edge TDO retiming is done in the top-level pad wrapper, not here.
- Boundary conditions:
  - Shifting more than IR_WIDTH bits keeps only the last IR_WIDTH tdi bits.
  - Update without a preceding capture/shift loads the stale ir_sr.
  - TRST mid-shift aborts immediately to reset values; no partial update.

Decomposition:
- Add to jtag_types_pkg:
  - IR_WIDTH = 5.
  - typedef logic [IR_WIDTH-1:0] instr_t.
  - Opcode constants: OP_EXTEST=5'b00000, OP_IDCODE=5'b00001, OP_SAMPLE_PRELOAD=5'b00010, OP_BYPASS=5'b11111.
  - IR_CAPTURE_PAT = 5'b00001.
- Natural sub-module: jtag_instr_decode, a combinational instr -> {bsr_sel, extest, idcode_sel, bypass_sel}.
- Registers and the TDO mux stay in jtag_ir_dr.

Test Plan:
- TRST pulse then release -> instr=5'b00001, bsr_sel=0, extest=0, tdo_en=0.
- ir_capture, then 5 ir_shift cycles with tdi=0 -> tdo sequence 1,0,0,0,0 with tdo_en=1.
- ir_capture, shift tdi 1,1,1,1,1, ir_update -> instr=5'b11111. Then dr_capture and dr_shift with tdi 1,0,1,1 -> tdo 0,1,0,1.
- After reset: dr_capture, then 32 dr_shift with tdi=0 -> tdo emits 32'h1000_0001 LSB first (1,0,...,0,1 at bit 28), then zeros.
- Load 5'b01010 (undefined) -> behaves as BYPASS. Load 5'b00000 -> bsr_sel=1, extest=1, and during dr_shift tdo tracks bsr_tdo.
- Load BYPASS, assert test_reset one cycle -> instr=OP_IDCODE. TRST low mid-IR-shift -> instr=OP_IDCODE and ir_sr=0 asynchronously.
